// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH  = 14;
  localparam int DEFAULT_DIGITS = 4;

  // Digit code that downstream 7-segment decoders render as blank.
  localparam logic [3:0] BLANK_DIGIT = 4'b1111;

  // Largest value representable in the given number of decimal digits.
  function automatic int max_value(input int digits);
    int p;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

  localparam int MAX_VALUE = max_value(DEFAULT_DIGITS);

endpackage

// File: rtl/bin_to_bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  // Pre-shift correction so the following left shift carries into the next digit.
  assign adj = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with valid/ready handshakes.
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MAX_BIN = WIDTH'(max_value(DIGITS));

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   bin_reg, bin_next;
  logic [BW-1:0]      work_reg, work_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic               ovfp_reg, ovfp_next;
  logic [BW-1:0]      bcd_reg, bcd_next;
  logic               ovf_reg, ovf_next;
  logic               out_valid_reg, out_valid_next;

  logic [BW-1:0]       work_adj;
  logic [BW+WIDTH-1:0] cat_shift;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit (work_reg[4*gi +: 4]),
        .adj   (work_adj[4*gi +: 4])
      );
    end
  endgenerate

  // One double-dabble step: corrected digits and remaining binary shifted left together.
  assign cat_shift = {work_adj, bin_reg} << 1;

  // Held low during reset so nothing is accepted while the block is being cleared.
  assign in_ready  = (state_reg == IDLE) && rst_n;
  assign out_valid = out_valid_reg;
  assign bcd       = bcd_reg;
  assign ovf       = ovf_reg;

  // Next-state and datapath decode; every register holds unless its state updates it.
  always_comb begin
    state_next     = state_reg;
    bin_next       = bin_reg;
    work_next      = work_reg;
    cnt_next       = cnt_reg;
    ovfp_next      = ovfp_reg;
    bcd_next       = bcd_reg;
    ovf_next       = ovf_reg;
    out_valid_next = out_valid_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          bin_next   = bin;
          work_next  = '0;
          cnt_next   = CW'(WIDTH);
          ovfp_next  = (bin > MAX_BIN);
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        bin_next  = cat_shift[WIDTH-1:0];
        work_next = cat_shift[BW+WIDTH-1:WIDTH];
        cnt_next  = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          bcd_next       = ovfp_reg ? {DIGITS{BLANK_DIGIT}} : cat_shift[BW+WIDTH-1:WIDTH];
          ovf_next       = ovfp_reg;
          out_valid_next = 1'b1;
          state_next     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      bin_reg       <= '0;
      work_reg      <= '0;
      cnt_reg       <= '0;
      ovfp_reg      <= 1'b0;
      bcd_reg       <= {DIGITS{BLANK_DIGIT}};
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bin_reg       <= bin_next;
      work_reg      <= work_next;
      cnt_reg       <= cnt_next;
      ovfp_reg      <= ovfp_next;
      bcd_reg       <= bcd_next;
      ovf_reg       <= ovf_next;
      out_valid_reg <= out_valid_next;
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq against a decimal-arithmetic reference.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] bcd;
  logic        ovf;

  int vectors;
  int miscompares;
  logic [15:0] prev_bcd;
  logic        prev_ovf;

  bin_to_bcd_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by division, all-blank above 9999.
  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int p;
    if (v > 9999) return 16'hFFFF;
    r = '0;
    p = 1;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full conversion starting in IDLE; optionally consume the result with out_ready high.
  task automatic run_conv(input int v, input bit consume);
    logic [15:0] exp_bcd;
    logic        exp_ovf;
    logic        quiet_ok;
    logic        hold_ok;
    exp_bcd = ref_bcd(v);
    exp_ovf = (v > 9999);
    check("accept_ready", in_ready, 1);
    in_valid = 1'b1;
    bin      = v[13:0];
    tick();
    in_valid = 1'b0;
    quiet_ok = 1'b1;
    hold_ok  = 1'b1;
    for (int e = 1; e < 14; e++) begin
      tick();
      if (out_valid !== 1'b0 || in_ready !== 1'b0) quiet_ok = 1'b0;
      if (bcd !== prev_bcd || ovf !== prev_ovf) hold_ok = 1'b0;
    end
    check("latency_quiet", quiet_ok, 1);
    check("hold_prev", hold_ok, 1);
    tick();
    check("out_valid_at_14", out_valid, 1);
    check("in_ready_done", in_ready, 0);
    check("bcd", bcd, exp_bcd);
    check("ovf", ovf, exp_ovf);
    $display("conv bin=%0d bcd=%h ovf=%0b exp_bcd=%h exp_ovf=%0b", v, bcd, ovf, exp_bcd, exp_ovf);
    prev_bcd = exp_bcd;
    prev_ovf = exp_ovf;
    if (consume) begin
      tick();
      check("consume_valid_low", out_valid, 0);
      check("consume_ready_high", in_ready, 1);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    bin         = '0;
    out_ready   = 1'b1;
    prev_bcd    = 16'hFFFF;
    prev_ovf    = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_bcd", bcd, 16'hFFFF);
    check("rst_out_valid", out_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1);
    $display("reset checked");

    // Nominal and boundary values
    run_conv(1234, 1'b1);
    run_conv(0, 1'b1);
    run_conv(9999, 1'b1);
    run_conv(10000, 1'b1);
    run_conv(16383, 1'b1);
    run_conv(8, 1'b1);

    // Backpressure: result held while a new request is offered
    out_ready = 1'b0;
    run_conv(4567, 1'b0);
    in_valid = 1'b1;
    bin      = 14'd77;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_bcd", bcd, 16'h4567);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    tick();
    check("bp_no_accept", in_ready, 1);
    check("bp_bcd_after", bcd, 16'h4567);
    $display("backpressure checked");
    run_conv(42, 1'b1);

    // Reset in the middle of a conversion
    in_valid = 1'b1;
    bin      = 14'd5678;
    tick();
    in_valid = 1'b0;
    for (int e = 1; e < 7; e++) tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_bcd", bcd, 16'hFFFF);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    tick();
    check("mid_rst_idle", in_ready, 1);
    check("mid_rst_idle_valid", out_valid, 0);
    $display("mid-conversion reset checked");
    prev_bcd = 16'hFFFF;
    prev_ovf = 1'b0;
    run_conv(5678, 1'b1);

    // Back-to-back random conversions
    for (int n = 0; n < 20; n++) begin
      run_conv(int'($urandom_range(0, 16383)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
